// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter_if
//  Brief    : Bundle of the two request ports, the Alu side-band and the
//             response/APSR outputs of alu_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if #(
  parameter int TAG_W = 4
);
  // Port 0 (execute stage)
  logic             req0_valid;
  logic             req0_ready;
  logic [3:0]       req0_op;
  logic [31:0]      req0_a;
  logic [31:0]      req0_b;
  logic             req0_setflags;
  logic [TAG_W-1:0] req0_tag;
  // Port 1 (address/compare unit)
  logic             req1_valid;
  logic             req1_ready;
  logic [3:0]       req1_op;
  logic [31:0]      req1_a;
  logic [31:0]      req1_b;
  logic             req1_setflags;
  logic [TAG_W-1:0] req1_tag;
  // Shared combinational Alu
  logic [3:0]       alu_opcode;
  logic [31:0]      alu_in1;
  logic [31:0]      alu_in2;
  logic [31:0]      alu_result;
  logic [3:0]       alu_flags;
  // Response stage and architectural flags
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_result;
  logic             resp_port;
  logic [TAG_W-1:0] resp_tag;
  logic             resp_err;
  logic [3:0]       apsr_nzcv;

  // Environment side: requesters, Alu and response consumer
  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req0_setflags, req0_tag,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b, req1_setflags, req1_tag,
    input  req1_ready,
    input  alu_opcode, alu_in1, alu_in2,
    output alu_result, alu_flags,
    input  resp_valid, resp_result, resp_port, resp_tag, resp_err, apsr_nzcv,
    output resp_ready
  );

  // Arbiter side
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req0_setflags, req0_tag,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b, req1_setflags, req1_tag,
    output req1_ready,
    output alu_opcode, alu_in1, alu_in2,
    input  alu_result, alu_flags,
    output resp_valid, resp_result, resp_port, resp_tag, resp_err, apsr_nzcv,
    input  resp_ready
  );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter
//  Brief    : Shares one combinational Alu between two valid/ready requesters,
//             registers the result in a one-entry response stage and owns the
//             architectural APSR.NZCV register.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int TAG_W    = 4,   // must match the TAG_W of the connected bus
  parameter int ARB_MODE = 0    // 0 = round-robin, 1 = fixed priority (port 0)
) (
  input  wire logic   clk,
  input  wire logic   rst,
  alu_arbiter_if.slave bus
);

  // Opcode encoding of alu_op_t; anything above EOR is reported as an error.
  localparam logic [3:0] c_OP_ADD = 4'd0;
  localparam logic [3:0] c_OP_SUB = 4'd1;
  localparam logic [3:0] c_OP_AND = 4'd2;
  localparam logic [3:0] c_OP_ORR = 4'd3;
  localparam logic [3:0] c_OP_EOR = 4'd4;

  // Registered state
  logic             r_resp_valid;
  logic [31:0]      r_resp_result;
  logic             r_resp_port;
  logic [TAG_W-1:0] r_resp_tag;
  logic             r_resp_err;
  logic [3:0]       r_apsr;
  logic             r_last_grant;

  // Arbitration and selected-request wires
  logic             w_slot_free;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_grant;
  logic             w_sel;
  logic [3:0]       w_op;
  logic [31:0]      w_a;
  logic [31:0]      w_b;
  logic             w_setflags;
  logic [TAG_W-1:0] w_tag;
  logic             w_err;
  logic             w_arith;
  logic             w_upd_flags;
  logic [3:0]       w_apsr_next;

  // The response register can take a new op when empty or drained this cycle.
  assign w_slot_free = !r_resp_valid || bus.resp_ready;

  generate
    if (ARB_MODE == 1) begin : g_fixed_prio
      // Port 0 always wins a contest.
      always_comb begin
        w_gnt0 = w_slot_free && bus.req0_valid;
        w_gnt1 = w_slot_free && bus.req1_valid && !bus.req0_valid;
      end
    end else begin : g_round_robin
      // In a contest the port that did not win last time is granted.
      always_comb begin
        w_gnt0 = w_slot_free && bus.req0_valid &&
                 (!bus.req1_valid || r_last_grant);
        w_gnt1 = w_slot_free && bus.req1_valid &&
                 (!bus.req0_valid || !r_last_grant);
      end
    end
  endgenerate

  assign w_grant = w_gnt0 || w_gnt1;
  assign w_sel   = w_gnt1;  // port 0 drives the Alu whenever port 1 is not granted

  assign bus.req0_ready = w_gnt0;
  assign bus.req1_ready = w_gnt1;

  // Operand mux feeding the shared Alu and the capture path.
  always_comb begin
    if (w_sel) begin
      w_op       = bus.req1_op;
      w_a        = bus.req1_a;
      w_b        = bus.req1_b;
      w_setflags = bus.req1_setflags;
      w_tag      = bus.req1_tag;
    end else begin
      w_op       = bus.req0_op;
      w_a        = bus.req0_a;
      w_b        = bus.req0_b;
      w_setflags = bus.req0_setflags;
      w_tag      = bus.req0_tag;
    end
  end

  assign bus.alu_opcode = w_op;
  assign bus.alu_in1    = w_a;
  assign bus.alu_in2    = w_b;

  assign w_err       = (w_op > c_OP_EOR);
  assign w_arith     = (w_op == c_OP_ADD) || (w_op == c_OP_SUB);
  assign w_upd_flags = w_grant && w_setflags && !w_err;

  // Next APSR: arithmetic ops replace all four flags, logical ops only N and Z.
  always_comb begin
    w_apsr_next = r_apsr;
    if (w_upd_flags) begin
      if (w_arith) begin
        w_apsr_next = bus.alu_flags;
      end else begin
        w_apsr_next[3:2] = bus.alu_flags[3:2];
      end
    end
  end

  // Response stage, APSR and round-robin history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp_valid  <= 1'b0;
      r_resp_result <= 32'd0;
      r_resp_port   <= 1'b0;
      r_resp_tag    <= '0;
      r_resp_err    <= 1'b0;
      r_apsr        <= 4'd0;
      r_last_grant  <= 1'b1;
    end else begin
      r_apsr <= w_apsr_next;
      if (w_grant) begin
        r_resp_valid  <= 1'b1;
        r_resp_result <= bus.alu_result;
        r_resp_port   <= w_sel;
        r_resp_tag    <= w_tag;
        r_resp_err    <= w_err;
        r_last_grant  <= w_sel;
      end else if (w_slot_free) begin
        r_resp_valid <= 1'b0;
      end
    end
  end

  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_result = r_resp_result;
  assign bus.resp_port   = r_resp_port;
  assign bus.resp_tag    = r_resp_tag;
  assign bus.resp_err    = r_resp_err;
  assign bus.apsr_nzcv   = r_apsr;

  // Opcodes kept for readability of the encoding table above.
  logic w_unused_ops;
  assign w_unused_ops = ^{c_OP_AND, c_OP_ORR};

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_arbiter
//  Brief    : Self-checking bench for alu_arbiter: directed scenarios followed
//             by randomized traffic against a transaction-level reference.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
  localparam int TAG_W    = 4;
  localparam int ARB_MODE = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_arbiter_if #(.TAG_W(TAG_W)) bus ();

  alu_arbiter #(.TAG_W(TAG_W), .ARB_MODE(ARB_MODE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Architectural Alu: returns {N,Z,C,V,result}
  function automatic logic [35:0] alu_ref(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic        c;
    logic        v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
                  v = (a[31] == b[31]) && (r[31] != a[31]); end
      4'd1: begin r = a - b; c = (a >= b);
                  v = (a[31] != b[31]) && (r[31] != a[31]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      default: r = 32'hFFFF_FFFF;
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  // External Alu seen by the DUT
  logic [35:0] alu_x;
  assign alu_x          = alu_ref(bus.alu_opcode, bus.alu_in1, bus.alu_in2);
  assign bus.alu_result = alu_x[31:0];
  assign bus.alu_flags  = alu_x[35:32];

  // Pending payload of each requester
  logic [3:0]       p_op  [2];
  logic [31:0]      p_a   [2];
  logic [31:0]      p_b   [2];
  logic             p_sf  [2];
  logic [TAG_W-1:0] p_tag [2];

  // Reference state: what the response stage and APSR should hold
  logic             m_valid;
  logic [31:0]      m_result;
  logic             m_port;
  logic [TAG_W-1:0] m_tag;
  logic             m_err;
  logic [3:0]       m_apsr;
  int               m_last;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_valid = 0; m_result = 0; m_port = 0; m_tag = 0; m_err = 0;
    m_apsr = 0; m_last = 1;
  endtask

  task automatic set_req(input int p, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic sf, input logic [TAG_W-1:0] tg);
    p_op[p] = op; p_a[p] = a; p_b[p] = b; p_sf[p] = sf; p_tag[p] = tg;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_req(input int p);
    logic [3:0] op;
    if ($urandom_range(0, 9) == 0) op = 4'($urandom_range(5, 15));
    else                           op = 4'($urandom_range(0, 4));
    set_req(p, op, rand_operand(), rand_operand(), 1'($urandom_range(0, 1)),
            TAG_W'($urandom));
  endtask

  // One clock cycle: drive, check grant, clock, check response state.
  task automatic step(input bit v0, input bit v1, input bit rr, output int g);
    bit          free;
    logic [35:0] x;
    bus.req0_valid = v0; bus.req0_op = p_op[0]; bus.req0_a = p_a[0];
    bus.req0_b = p_b[0]; bus.req0_setflags = p_sf[0]; bus.req0_tag = p_tag[0];
    bus.req1_valid = v1; bus.req1_op = p_op[1]; bus.req1_a = p_a[1];
    bus.req1_b = p_b[1]; bus.req1_setflags = p_sf[1]; bus.req1_tag = p_tag[1];
    bus.resp_ready = rr;
    free = !m_valid || rr;
    g = -1;
    if (free) begin
      if (v0 && v1) g = (ARB_MODE == 1) ? 0 : ((m_last == 0) ? 1 : 0);
      else if (v0)  g = 0;
      else if (v1)  g = 1;
    end
    #1;
    chk("req0_ready", 64'(bus.req0_ready), 64'(g == 0));
    chk("req1_ready", 64'(bus.req1_ready), 64'(g == 1));
    chk("alu_in1", 64'(bus.alu_in1), 64'((g == 1) ? p_a[1] : p_a[0]));
    @(posedge clk);
    if (g >= 0) begin
      x        = alu_ref(p_op[g], p_a[g], p_b[g]);
      m_valid  = 1;
      m_result = x[31:0];
      m_port   = 1'(g);
      m_tag    = p_tag[g];
      m_err    = (p_op[g] > 4'd4);
      if (p_sf[g] && !m_err) begin
        if (p_op[g] <= 4'd1) m_apsr = x[35:32];
        else                 m_apsr = {x[35:34], m_apsr[1:0]};
      end
      m_last = g;
    end else if (free) begin
      m_valid = 0;
    end
    #1;
    chk("resp_valid",  64'(bus.resp_valid),  64'(m_valid));
    chk("resp_result", 64'(bus.resp_result), 64'(m_result));
    chk("resp_port",   64'(bus.resp_port),   64'(m_port));
    chk("resp_tag",    64'(bus.resp_tag),    64'(m_tag));
    chk("resp_err",    64'(bus.resp_err),    64'(m_err));
    chk("apsr_nzcv",   64'(bus.apsr_nzcv),   64'(m_apsr));
  endtask

  initial begin
    int g;
    int exp_ports[4];
    bit rv0;
    bit rv1;
    exp_ports = '{0, 1, 0, 1};
    rst = 1'b1;
    m_reset();
    for (int p = 0; p < 2; p++) set_req(p, 4'd0, 32'd0, 32'd0, 1'b0, '0);
    bus.req0_valid = 0; bus.req0_op = 0; bus.req0_a = 0; bus.req0_b = 0;
    bus.req0_setflags = 0; bus.req0_tag = 0;
    bus.req1_valid = 0; bus.req1_op = 0; bus.req1_a = 0; bus.req1_b = 0;
    bus.req1_setflags = 0; bus.req1_tag = 0;
    bus.resp_ready = 1'b0;
    #2;
    chk("rst_resp_valid",  64'(bus.resp_valid),  64'd0);
    chk("rst_resp_result", 64'(bus.resp_result), 64'd0);
    chk("rst_resp_tag",    64'(bus.resp_tag),    64'd0);
    chk("rst_apsr",        64'(bus.apsr_nzcv),   64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Round-robin alternation with both ports always valid
    set_req(0, 4'd2, 32'hF0, 32'h3C, 1'b0, 4'd0);
    set_req(1, 4'd3, 32'h01, 32'h02, 1'b0, 4'd1);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 1, g);
      chk("rr_port", 64'(bus.resp_port), 64'(exp_ports[i]));
      chk("rr_tag",  64'(bus.resp_tag),  64'(i));
      set_req(g, p_op[g], p_a[g] + 1, p_b[g], 1'b0, TAG_W'(i + 2));
    end

    // ADD overflow into the sign bit
    set_req(0, 4'd0, 32'h7FFF_FFFF, 32'd1, 1'b1, 4'd9);
    step(1, 0, 1, g);
    chk("add_result", 64'(bus.resp_result), 64'h8000_0000);
    chk("add_apsr",   64'(bus.apsr_nzcv),   64'b1001);

    // SUB sets C and Z; a following AND keeps C and V
    set_req(0, 4'd1, 32'd5, 32'd5, 1'b1, 4'd3);
    step(1, 0, 1, g);
    chk("sub_apsr", 64'(bus.apsr_nzcv), 64'b0110);
    set_req(1, 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'd4);
    step(0, 1, 1, g);
    chk("and_apsr", 64'(bus.apsr_nzcv), 64'b1010);

    // Illegal opcode: error flagged, APSR untouched
    set_req(0, 4'hF, 32'h1234, 32'h5678, 1'b1, 4'd5);
    step(1, 0, 1, g);
    chk("err_flag",   64'(bus.resp_err),    64'd1);
    chk("err_result", 64'(bus.resp_result), 64'hFFFF_FFFF);
    chk("err_apsr",   64'(bus.apsr_nzcv),   64'b1010);

    // Back-pressure: no grant and a frozen response until ready returns
    set_req(0, 4'd4, 32'hAAAA_0000, 32'h0000_5555, 1'b0, 4'd6);
    step(1, 0, 1, g);
    set_req(0, 4'd0, 32'd10, 32'd20, 1'b0, 4'd7);
    set_req(1, 4'd1, 32'd30, 32'd20, 1'b0, 4'd8);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, g);
      chk("bp_no_grant", 64'(g), 64'(-1));
      chk("bp_hold", 64'(bus.resp_result), 64'hAAAA_5555);
    end
    step(1, 1, 1, g);
    chk("bp_one_grant", 64'(bus.resp_tag), 64'd8);

    // Asynchronous reset with a response in flight
    chk("pre_rst_valid", 64'(bus.resp_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(bus.resp_valid), 64'd0);
    chk("arst_apsr",  64'(bus.apsr_nzcv),  64'd0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1, 1, 1, g);
    chk("post_rst_port", 64'(bus.resp_port), 64'd0);

    // Randomized traffic; requesters hold their payload until accepted
    rv0 = 0;
    rv1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (!rv0) begin rv0 = 1'($urandom_range(0, 1)); rand_req(0); end
      if (!rv1) begin rv1 = 1'($urandom_range(0, 1)); rand_req(1); end
      step(rv0, rv1, ($urandom_range(0, 3) != 0), g);
      if (g == 0) rv0 = 0;
      if (g == 1) rv1 = 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
